// File: rtl/bin_to_bcd_6dig_pkg.sv
// bin_to_bcd_6dig_pkg: shared states, default sizes and constants for the BCD converter
package bin_to_bcd_6dig_pkg;
  localparam int BIN_W_DEF = 20;
  localparam int DIGITS_DEF = 6;
  localparam logic [3:0] BCD_ALL_NINES = 4'h9;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  function automatic longint pow10(input int n);
    longint r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/bin_to_bcd_6dig_if.sv
// bin_to_bcd_6dig_if: start/done request bus between a producer and the converter
interface bin_to_bcd_6dig_if
  import bin_to_bcd_6dig_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
);
  logic iStart;
  logic [BIN_W-1:0] iBin;
  logic oBusy;
  logic oDone;
  logic [4*DIGITS-1:0] oBCD;
  logic oOvf;
  modport master(output iStart, iBin, input oBusy, oDone, oBCD, oOvf);
  modport slave(input iStart, iBin, output oBusy, oDone, oBCD, oOvf);
endinterface

// File: rtl/bin_to_bcd_6dig_adj.sv
// bcd_digit_adj: double-dabble nibble correction, adds 3 to any digit of 5 or more
module bcd_digit_adj (
  input  logic [3:0] iDig,
  output logic [3:0] oDig
);
  assign oDig = (iDig >= 4'd5) ? iDig + 4'd3 : iDig;
endmodule

// File: rtl/bin_to_bcd_6dig.sv
// bin_to_bcd_6dig: sequential shift-and-add-3 binary to packed BCD converter with saturation
module bin_to_bcd_6dig
  import bin_to_bcd_6dig_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input logic iCLK,
  input logic iRST_N,
  bin_to_bcd_6dig_if.slave bus
);
  localparam int SR_W = 4 * DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(pow10(DIGITS) - 1);

  if (pow10(DIGITS) - 1 >= (longint'(1) << BIN_W)) begin : gBadWidth
    $error("BIN_W too narrow to hold 10^DIGITS-1");
  end

  state_t state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0] sr, shifted;
  logic [4*DIGITS-1:0] adj, bcdQ;
  logic ovfQ, ovfOut, doneQ, lastShift;

  for (genvar d = 0; d < DIGITS; d++) begin : gAdj
    bcd_digit_adj uAdj (.iDig(sr[BIN_W+4*d +: 4]), .oDig(adj[4*d +: 4]));
  end

  assign shifted = {adj, sr[BIN_W-1:0]} << 1;

  // Next state: leave IDLE on a request, leave SHIFT after the final shift
  always_comb begin
    lastShift = (state == ST_SHIFT) && (cnt == CNT_W'(BIN_W - 1));
    stateNext = (state == ST_IDLE) ? (bus.iStart ? ST_SHIFT : ST_IDLE)
                                   : (lastShift ? ST_IDLE : ST_SHIFT);
  end

  // State, datapath and held outputs; a reset mid-conversion drops the partial result
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= ST_IDLE;
      cnt <= '0;
      sr <= '0;
      ovfQ <= 1'b0;
      ovfOut <= 1'b0;
      bcdQ <= '0;
      doneQ <= 1'b0;
    end else begin
      state <= stateNext;
      doneQ <= lastShift;
      if (state == ST_IDLE && bus.iStart) begin
        sr <= {{(4*DIGITS){1'b0}}, bus.iBin};
        cnt <= '0;
        ovfQ <= bus.iBin > MAX_VAL;
      end else if (state == ST_SHIFT) begin
        sr <= shifted;
        cnt <= cnt + CNT_W'(1);
      end
      if (lastShift) begin
        bcdQ <= ovfQ ? {DIGITS{BCD_ALL_NINES}} : shifted[SR_W-1 -: 4*DIGITS];
        ovfOut <= ovfQ;
      end
    end
  end

  assign bus.oBusy = (state == ST_SHIFT);
  assign bus.oDone = doneQ;
  assign bus.oBCD = bcdQ;
  assign bus.oOvf = ovfOut;
endmodule

// File: tb/tb_bin_to_bcd_6dig.sv
// tb_bin_to_bcd_6dig: directed and random checks of the BCD converter against a decimal model
module tb_bin_to_bcd_6dig;
  localparam int BIN_W = 20;
  localparam int DIGITS = 6;
  localparam int LAT = BIN_W;

  logic iCLK = 1'b0;
  logic iRST_N;
  int nChecks = 0;
  int nErrors = 0;
  int doneCnt = 0;

  bin_to_bcd_6dig_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();
  bin_to_bcd_6dig #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));

  always #5 iCLK = ~iCLK;

  // Count every oDone pulse, sampled away from the rising edge
  always @(negedge iCLK) if (bus.oDone === 1'b1) doneCnt++;

  function automatic logic [23:0] refBcd(input int unsigned v);
    logic [23:0] r = '0;
    if (v > 999999) return 24'h999999;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic startConv(input int unsigned v);
    @(negedge iCLK);
    bus.iStart = 1'b1;
    bus.iBin = 20'(v);
    @(posedge iCLK);
    #1;
    bus.iStart = 1'b0;
    bus.iBin = 20'($urandom);
  endtask

  task automatic waitDone(output int lat);
    int busyBad = 0;
    lat = 0;
    do begin
      @(posedge iCLK);
      #1;
      lat++;
      if (!bus.oDone && bus.oBusy !== 1'b1) busyBad++;
    end while (bus.oDone !== 1'b1 && lat < 100);
    checkVal("doneSeen", 32'(bus.oDone), 1);
    checkVal("busyDuring", busyBad, 0);
    checkVal("busyAtDone", 32'(bus.oBusy), 0);
  endtask

  task automatic convCheck(input int unsigned v, input string tag);
    int lat;
    startConv(v);
    waitDone(lat);
    checkVal({tag, ".lat"}, lat, LAT);
    checkVal({tag, ".bcd"}, 32'(bus.oBCD), 32'(refBcd(v)));
    checkVal({tag, ".ovf"}, 32'(bus.oOvf), 32'(v > 999999));
    @(posedge iCLK);
    #1;
    checkVal({tag, ".pulse"}, 32'(bus.oDone), 0);
  endtask

  initial begin
    int lat;
    int d0;
    int unsigned v;
    logic [23:0] exp;
    iRST_N = 1'b0;
    bus.iStart = 1'b0;
    bus.iBin = '0;
    repeat (2) @(posedge iCLK);
    #1;
    checkVal("rst.busy", 32'(bus.oBusy), 0);
    checkVal("rst.done", 32'(bus.oDone), 0);
    checkVal("rst.bcd", 32'(bus.oBCD), 0);
    checkVal("rst.ovf", 32'(bus.oOvf), 0);
    @(negedge iCLK);
    iRST_N = 1'b1;

    convCheck(0, "zero");
    convCheck(123456, "d123456");
    convCheck(999999, "d999999");
    convCheck(1000000, "ovf1M");
    convCheck(20'hFFFFF, "ovfMax");

    d0 = doneCnt;
    startConv(4321);
    repeat (5) begin
      @(posedge iCLK);
      #1;
    end
    bus.iStart = 1'b1;
    bus.iBin = 20'd7;
    @(posedge iCLK);
    #1;
    bus.iStart = 1'b0;
    waitDone(lat);
    checkVal("ignore.lat", lat, LAT - 6);
    checkVal("ignore.bcd", 32'(bus.oBCD), 32'h004321);
    repeat (30) @(posedge iCLK);
    #1;
    checkVal("ignore.single", doneCnt - d0, 1);
    checkVal("ignore.hold", 32'(bus.oBCD), 32'h004321);

    // Held start: each request is accepted in the done cycle of the previous one
    @(negedge iCLK);
    bus.iStart = 1'b1;
    bus.iBin = 20'd42;
    v = 42;
    @(posedge iCLK);
    #1;
    for (int k = 0; k < 4; k++) begin
      waitDone(lat);
      checkVal("b2b.lat", lat, LAT);
      checkVal("b2b.bcd", 32'(bus.oBCD), 32'(refBcd(v)));
      v = (v == 42) ? 58 : 42;
      bus.iBin = 20'(v);
      @(posedge iCLK);
      #1;
      checkVal("b2b.busy", 32'(bus.oBusy), 1);
      checkVal("b2b.pulse", 32'(bus.oDone), 0);
    end
    bus.iStart = 1'b0;
    waitDone(lat);
    checkVal("b2b.tail", 32'(bus.oBCD), 32'(refBcd(v)));

    convCheck(555555, "pre");
    startConv(111);
    repeat (9) begin
      @(posedge iCLK);
      #1;
    end
    @(negedge iCLK);
    iRST_N = 1'b0;
    @(posedge iCLK);
    #1;
    checkVal("midrst.bcd", 32'(bus.oBCD), 0);
    checkVal("midrst.busy", 32'(bus.oBusy), 0);
    checkVal("midrst.done", 32'(bus.oDone), 0);
    checkVal("midrst.ovf", 32'(bus.oOvf), 0);
    @(negedge iCLK);
    iRST_N = 1'b1;
    d0 = doneCnt;
    repeat (30) @(posedge iCLK);
    #1;
    checkVal("midrst.nodone", doneCnt - d0, 0);
    convCheck(9, "after");

    for (int k = 0; k < 30; k++) begin
      v = (k % 3 == 0) ? $urandom_range(20'hFFFFF, 0) : $urandom_range(999999, 0);
      exp = refBcd(v);
      startConv(v);
      waitDone(lat);
      checkVal("rnd.lat", lat, LAT);
      checkVal("rnd.bcd", 32'(bus.oBCD), 32'(exp));
      checkVal("rnd.ovf", 32'(bus.oOvf), 32'(v > 999999));
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule
